// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the PC register and decode.
// Issues one instruction-memory read per accepted PC, tracks the single
// outstanding read, and queues returned {instruction, PC} pairs in a
// DEPTH-entry circular buffer that decode drains from the head.
//
// Ports:
//   clk          single clock, rising-edge state updates
//   rst          asynchronous active-low reset
//   pc           fetch address from the PC register
//   pc_valid     pc holds a fetch request
//   pc_ready     request accepted this cycle (PC register advances on it)
//   flush        branch taken: drop every queued and in-flight fetch
//   mem_en       instruction memory read strobe
//   mem_addr     instruction memory read address (equals pc)
//   mem_rdata    read data, returned one cycle after mem_en
//   instr_valid  queue head holds an instruction
//   instr_ready  decode consumes the head this cycle
//   instr        head instruction word
//   instr_pc     PC of the head instruction
//   count        number of queued entries
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             pc,
  input  logic                         pc_valid,
  output logic                         pc_ready,
  input  logic                         flush,
  output logic                         mem_en,
  output logic [WIDTH-1:0]             mem_addr,
  input  logic [31:0]                  mem_rdata,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [31:0]                  instr,
  output logic [WIDTH-1:0]             instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] LP_DEPTH  = CW'(DEPTH);
  localparam logic [CW:0]   LP_DEPTH1 = (CW+1)'(DEPTH);

  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic             r_inflight;
  logic [WIDTH-1:0] r_inflight_pc;
  logic [31:0]      r_instr_mem [DEPTH];
  logic [WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [31:0]      r_last_instr;
  logic [WIDTH-1:0] r_last_pc;

  logic             w_pop;
  logic             w_push;
  logic [CW:0]      w_occ;

  // Occupancy seen by a new request: queued entries plus the read still in
  // flight, minus the entry leaving this cycle. count is never zero when
  // pop is high, so this cannot wrap.
  assign w_occ  = (CW+1)'(r_count) + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  assign instr_valid = rst && (r_count != '0) && !flush;
  assign w_pop       = instr_valid && instr_ready;
  assign w_push      = r_inflight && !flush;

  // rst gates the request path so no read is strobed while in reset.
  assign pc_ready = rst && !flush && (w_occ < LP_DEPTH1);
  assign mem_en   = pc_valid && pc_ready;
  assign mem_addr = pc;
  assign count    = r_count;

  // When empty, the outputs hold the entry most recently consumed.
  assign instr    = (r_count != '0) ? r_instr_mem[r_head] : r_last_instr;
  assign instr_pc = (r_count != '0) ? r_pc_mem[r_head]    : r_last_pc;

  // Control state: occupancy, pointers and the outstanding-read tracker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_last_instr  <= '0;
      r_last_pc     <= '0;
    end else if (flush) begin
      // A read returning now is dropped because push is masked; one returning
      // next cycle is dropped because the in-flight flag is cleared here.
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= mem_en;
      if (mem_en) r_inflight_pc <= pc;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop) begin
        r_head       <= r_head + PW'(1);
        r_last_instr <= r_instr_mem[r_head];
        r_last_pc    <= r_pc_mem[r_head];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_tail] <= mem_rdata;
      r_pc_mem[r_tail]    <= r_inflight_pc;
    end
  end

  // pc_ready reserves a slot for every issued read, so a push can never
  // land on a full queue.
  always @(posedge clk) begin
    if (rst && w_push) assert (r_count < LP_DEPTH);
  end

endmodule
